// File: rtl/vdp_vram_pkg.sv
// Shared types and constants for the VDP VRAM slot responder.
//   slot_owner_t  : who owns the current VRAM access slot
//   slot_state_t  : position inside the 4-clock slot
//   wr_entry_t    : buffered CPU write (address + data)
//   DS_*          : DOTSTATE phase encodings (10 -> 00 -> 01 -> 11)
//   vram_phys()   : logical -> physical VRAM address mapping
package vdp_vram_pkg;

   localparam int unsigned VRAM_ADR_W = 17;
   localparam int unsigned VRAM_DAT_W = 8;

   localparam logic [1:0] DS_10 = 2'b10;
   localparam logic [1:0] DS_00 = 2'b00;
   localparam logic [1:0] DS_01 = 2'b01;
   localparam logic [1:0] DS_11 = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      SPRITE,
      CPU_WR,
      CPU_RD
   } slot_owner_t;

   typedef enum logic [1:0] {
      SL_IDLE,
      SL_ISSUE,
      SL_CAPTURE,
      SL_RELEASE
   } slot_state_t;

   typedef struct packed {
      logic [VRAM_ADR_W-1:0] adr;
      logic [VRAM_DAT_W-1:0] dat;
   } wr_entry_t;

   // Interleave mode rotates the byte-lane bit to the top of the address.
   function automatic logic [VRAM_ADR_W-1:0] vram_phys(
      input logic [VRAM_ADR_W-1:0] a,
      input logic                  interleave
   );
      return interleave ? {a[0], a[VRAM_ADR_W-1:1]} : a;
   endfunction

endpackage

// File: rtl/vdp_vram_wr_fifo.sv
// CPU write buffer for the VRAM slot responder.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset, flushes all entries
//   push_i       : enqueue push_data_i (ignored when full)
//   push_data_i  : entry to enqueue
//   pop_i        : dequeue head (ignored when empty)
//   head_o       : oldest entry
//   full_o       : no free entry
//   empty_o      : no entry stored
module vdp_vram_wr_fifo
   import vdp_vram_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  wr_entry_t push_data_i,
   input  logic      pop_i,
   output wr_entry_t head_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   wr_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   cnt_q;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the pre-edge count, so a push coinciding with a pop
   // on a full buffer is rejected.
   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/vdp_vram_slot_responder.sv
// VRAM-side responder: one SRAM access slot per 4-clock dot, shared between
// the sprite engine read port and a buffered CPU write / CPU read path.
//   CLK21M, RESET              : clock, synchronous active-high reset
//   DOTSTATE                   : dot phase, slot starts on the 10 phase
//   VRAMINTERLEAVEMODE         : physical address = {A[0],A[16:1]} when 1
//   SPVRAMACCESSING, PRAMADR   : sprite claims the slot / read address
//   PRAMDAT                    : sprite read data (held until next capture)
//   CPU_WR_REQ/ADR/DAT, _ACK   : CPU write request, 1-cycle accept pulse
//   CPU_RD_REQ/ADR, _DAT, _ACK : CPU read request, data with 1-cycle pulse
//   MEM_ADR/OE/WE/DOUT, MEM_DIN: async SRAM interface
module vdp_vram_slot_responder
   import vdp_vram_pkg::*;
#(
   parameter int unsigned ADR_W       = VRAM_ADR_W,
   parameter int unsigned DAT_W       = VRAM_DAT_W,
   parameter int unsigned WFIFO_DEPTH = 2
) (
   input  logic             CLK21M,
   input  logic             RESET,
   input  logic [1:0]       DOTSTATE,
   input  logic             VRAMINTERLEAVEMODE,
   input  logic             SPVRAMACCESSING,
   input  logic [ADR_W-1:0] PRAMADR,
   output logic [DAT_W-1:0] PRAMDAT,
   input  logic             CPU_WR_REQ,
   input  logic [ADR_W-1:0] CPU_WR_ADR,
   input  logic [DAT_W-1:0] CPU_WR_DAT,
   output logic             CPU_WR_ACK,
   input  logic             CPU_RD_REQ,
   input  logic [ADR_W-1:0] CPU_RD_ADR,
   output logic [DAT_W-1:0] CPU_RD_DAT,
   output logic             CPU_RD_ACK,
   output logic [ADR_W-1:0] MEM_ADR,
   output logic             MEM_OE,
   output logic             MEM_WE,
   output logic [DAT_W-1:0] MEM_DOUT,
   input  logic [DAT_W-1:0] MEM_DIN
);

   slot_state_t      slot_q,     slot_d;
   slot_owner_t      owner_q,    owner_d;
   logic [ADR_W-1:0] mem_adr_q,  mem_adr_d;
   logic             mem_oe_q,   mem_oe_d;
   logic             mem_we_q,   mem_we_d;
   logic [DAT_W-1:0] mem_dout_q, mem_dout_d;
   logic [DAT_W-1:0] pramdat_q,  pramdat_d;
   logic [DAT_W-1:0] rd_dat_q,   rd_dat_d;
   logic             rd_ack_q,   rd_ack_d;
   logic             wr_ack_q,   wr_ack_d;
   logic             rd_pend_q,  rd_pend_d;
   logic [ADR_W-1:0] rd_adr_q,   rd_adr_d;
   logic             rd_done_q,  rd_done_d;

   logic      fifo_push;
   logic      fifo_pop;
   logic      fifo_full;
   logic      fifo_empty;
   wr_entry_t fifo_in;
   wr_entry_t fifo_head;

   assign fifo_in = '{adr: CPU_WR_ADR, dat: CPU_WR_DAT};

   vdp_vram_wr_fifo #(
      .DEPTH (WFIFO_DEPTH)
   ) u_wr_fifo (
      .clk_i       (CLK21M),
      .rst_i       (RESET),
      .push_i      (fifo_push),
      .push_data_i (fifo_in),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      slot_d     = slot_q;
      owner_d    = owner_q;
      mem_adr_d  = mem_adr_q;
      mem_oe_d   = mem_oe_q;
      mem_we_d   = mem_we_q;
      mem_dout_d = mem_dout_q;
      pramdat_d  = pramdat_q;
      rd_dat_d   = rd_dat_q;
      rd_ack_d   = 1'b0;
      wr_ack_d   = 1'b0;
      rd_pend_d  = rd_pend_q;
      rd_adr_d   = rd_adr_q;
      rd_done_d  = rd_done_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;

      // Write accept; the ACK cycle blocks a second push of the same request.
      if (CPU_WR_REQ && !fifo_full && !wr_ack_q) begin
         fifo_push = 1'b1;
         wr_ack_d  = 1'b1;
      end

      // Read latch re-arms only after REQ has been seen low following an ACK.
      if (!CPU_RD_REQ) rd_done_d = 1'b0;
      if (CPU_RD_REQ && !rd_pend_q && !rd_done_q) begin
         rd_pend_d = 1'b1;
         rd_adr_d  = CPU_RD_ADR;
      end

      case (slot_q)
         SL_IDLE: begin
            mem_oe_d = 1'b0;
            mem_we_d = 1'b0;
            owner_d  = IDLE;
            if (DOTSTATE == DS_10) begin
               if (SPVRAMACCESSING) begin
                  owner_d   = SPRITE;
                  mem_adr_d = vram_phys(PRAMADR, VRAMINTERLEAVEMODE);
                  mem_oe_d  = 1'b1;
                  slot_d    = SL_ISSUE;
               end else if (!fifo_empty) begin
                  owner_d    = CPU_WR;
                  mem_adr_d  = vram_phys(fifo_head.adr, VRAMINTERLEAVEMODE);
                  mem_dout_d = fifo_head.dat;
                  mem_we_d   = 1'b1;
                  slot_d     = SL_ISSUE;
               end else if (rd_pend_q) begin
                  // Reached only with an empty write buffer: reads never
                  // overtake buffered writes.
                  owner_d   = CPU_RD;
                  mem_adr_d = vram_phys(rd_adr_q, VRAMINTERLEAVEMODE);
                  mem_oe_d  = 1'b1;
                  slot_d    = SL_ISSUE;
               end
            end
         end
         SL_ISSUE: begin
            mem_we_d = 1'b0;
            slot_d   = SL_CAPTURE;
            case (owner_q)
               SPRITE: pramdat_d = MEM_DIN;
               CPU_WR: fifo_pop  = 1'b1;
               CPU_RD: begin
                  rd_dat_d  = MEM_DIN;
                  rd_ack_d  = 1'b1;
                  rd_pend_d = 1'b0;
                  rd_done_d = 1'b1;
               end
               default: ;
            endcase
         end
         SL_CAPTURE: begin
            mem_oe_d = 1'b0;
            slot_d   = SL_RELEASE;
         end
         SL_RELEASE: begin
            slot_d  = SL_IDLE;
            owner_d = IDLE;
         end
         default: slot_d = SL_IDLE;
      endcase
   end

   always_ff @(posedge CLK21M) begin
      if (RESET) begin
         slot_q     <= SL_IDLE;
         owner_q    <= IDLE;
         mem_adr_q  <= '0;
         mem_oe_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_dout_q <= '0;
         pramdat_q  <= '0;
         rd_dat_q   <= '0;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_adr_q   <= '0;
         rd_done_q  <= 1'b0;
      end else begin
         slot_q     <= slot_d;
         owner_q    <= owner_d;
         mem_adr_q  <= mem_adr_d;
         mem_oe_q   <= mem_oe_d;
         mem_we_q   <= mem_we_d;
         mem_dout_q <= mem_dout_d;
         pramdat_q  <= pramdat_d;
         rd_dat_q   <= rd_dat_d;
         rd_ack_q   <= rd_ack_d;
         wr_ack_q   <= wr_ack_d;
         rd_pend_q  <= rd_pend_d;
         rd_adr_q   <= rd_adr_d;
         rd_done_q  <= rd_done_d;
      end
   end

   assign PRAMDAT    = pramdat_q;
   assign CPU_WR_ACK = wr_ack_q;
   assign CPU_RD_DAT = rd_dat_q;
   assign CPU_RD_ACK = rd_ack_q;
   assign MEM_ADR    = mem_adr_q;
   assign MEM_OE     = mem_oe_q;
   assign MEM_WE     = mem_we_q;
   assign MEM_DOUT   = mem_dout_q;

endmodule

// File: tb/tb_vdp_vram_slot_responder.sv
// Directed bench for vdp_vram_slot_responder with a behavioural async SRAM.
module tb_vdp_vram_slot_responder;

   logic        clk;
   logic        RESET;
   logic [1:0]  DOTSTATE;
   logic        VRAMINTERLEAVEMODE;
   logic        SPVRAMACCESSING;
   logic [16:0] PRAMADR;
   logic [7:0]  PRAMDAT;
   logic        CPU_WR_REQ;
   logic [16:0] CPU_WR_ADR;
   logic [7:0]  CPU_WR_DAT;
   logic        CPU_WR_ACK;
   logic        CPU_RD_REQ;
   logic [16:0] CPU_RD_ADR;
   logic [7:0]  CPU_RD_DAT;
   logic        CPU_RD_ACK;
   logic [16:0] MEM_ADR;
   logic        MEM_OE;
   logic        MEM_WE;
   logic [7:0]  MEM_DOUT;
   logic [7:0]  MEM_DIN;

   vdp_vram_slot_responder #(
      .ADR_W       (17),
      .DAT_W       (8),
      .WFIFO_DEPTH (2)
   ) dut (
      .CLK21M             (clk),
      .RESET              (RESET),
      .DOTSTATE           (DOTSTATE),
      .VRAMINTERLEAVEMODE (VRAMINTERLEAVEMODE),
      .SPVRAMACCESSING    (SPVRAMACCESSING),
      .PRAMADR            (PRAMADR),
      .PRAMDAT            (PRAMDAT),
      .CPU_WR_REQ         (CPU_WR_REQ),
      .CPU_WR_ADR         (CPU_WR_ADR),
      .CPU_WR_DAT         (CPU_WR_DAT),
      .CPU_WR_ACK         (CPU_WR_ACK),
      .CPU_RD_REQ         (CPU_RD_REQ),
      .CPU_RD_ADR         (CPU_RD_ADR),
      .CPU_RD_DAT         (CPU_RD_DAT),
      .CPU_RD_ACK         (CPU_RD_ACK),
      .MEM_ADR            (MEM_ADR),
      .MEM_OE             (MEM_OE),
      .MEM_WE             (MEM_WE),
      .MEM_DOUT           (MEM_DOUT),
      .MEM_DIN            (MEM_DIN)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model, write log and event counters
   logic [7:0]  vram [0:131071];
   logic        pre_en;
   logic [16:0] pre_adr;
   logic [7:0]  pre_dat;
   int unsigned cyc;
   int unsigned we_cnt;
   int unsigned wr_ack_cnt;
   int unsigned rd_ack_cnt;
   logic [16:0] wl_adr [$];
   logic [7:0]  wl_dat [$];
   int unsigned wl_cyc [$];

   assign MEM_DIN = vram[MEM_ADR];

   initial begin
      cyc = 0; we_cnt = 0; wr_ack_cnt = 0; rd_ack_cnt = 0;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pre_en) begin
         vram[pre_adr] <= pre_dat;
      end else if (MEM_WE === 1'b1) begin
         vram[MEM_ADR] <= MEM_DOUT;
         we_cnt <= we_cnt + 1;
         wl_adr.push_back(MEM_ADR);
         wl_dat.push_back(MEM_DOUT);
         wl_cyc.push_back(cyc);
      end
      if (CPU_WR_ACK === 1'b1) wr_ack_cnt <= wr_ack_cnt + 1;
      if (CPU_RD_ACK === 1'b1) rd_ack_cnt <= rd_ack_cnt + 1;
   end

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [1:0]  ds_idx;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ds_seq(input logic [1:0] idx);
      case (idx)
         2'd0:    return 2'b10;
         2'd1:    return 2'b00;
         2'd2:    return 2'b01;
         default: return 2'b11;
      endcase
   endfunction

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      ds_idx   = ds_idx + 2'd1;
      DOTSTATE = ds_seq(ds_idx);
   endtask

   // Returns just after the edge that sampled DOTSTATE==10.
   task automatic wait_slot_start();
      for (int i = 0; i < 4 && DOTSTATE != 2'b10; i++) tick();
      tick();
   endtask

   task automatic preload(input logic [16:0] a, input logic [7:0] d);
      pre_en = 1'b1; pre_adr = a; pre_dat = d;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic cpu_write(input logic [16:0] a, input logic [7:0] d,
                            input int max_cyc, output bit acked);
      CPU_WR_ADR = a; CPU_WR_DAT = d; CPU_WR_REQ = 1'b1;
      acked = 1'b0;
      for (int i = 0; i < max_cyc && !acked; i++) begin
         tick();
         if (CPU_WR_ACK === 1'b1) acked = 1'b1;
      end
      if (acked) CPU_WR_REQ = 1'b0;
   endtask

   task automatic cpu_read(input logic [16:0] a, input int max_cyc, output bit acked,
                           output logic [7:0] d, output int unsigned at_cyc);
      CPU_RD_ADR = a; CPU_RD_REQ = 1'b1;
      acked = 1'b0; d = '0; at_cyc = 0;
      for (int i = 0; i < max_cyc && !acked; i++) begin
         tick();
         if (CPU_RD_ACK === 1'b1) begin
            acked = 1'b1; d = CPU_RD_DAT; at_cyc = cyc;
         end
      end
      CPU_RD_REQ = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bit          ok;
      logic [7:0]  rd;
      int unsigned rcyc, ack_cyc, we0, rd0, wa0;

      RESET = 1'b1; ds_idx = 2'd0; DOTSTATE = 2'b10;
      VRAMINTERLEAVEMODE = 1'b0; SPVRAMACCESSING = 1'b0; PRAMADR = '0;
      CPU_WR_REQ = 1'b0; CPU_WR_ADR = '0; CPU_WR_DAT = '0;
      CPU_RD_REQ = 1'b0; CPU_RD_ADR = '0;
      pre_en = 1'b0; pre_adr = '0; pre_dat = '0;

      // Reset state; preload SRAM while in reset
      preload(17'h01E00, 8'hD8);
      preload(17'h11C00, 8'h3C);
      preload(17'h03801, 8'h7E);
      preload(17'h00100, 8'h11);
      preload(17'h00400, 8'h9C);
      preload(17'h01C00, 8'h00);
      chk("rst_pramdat",  32'(PRAMDAT), 32'h0);
      chk("rst_wr_ack",   32'(CPU_WR_ACK), 32'h0);
      chk("rst_rd_dat",   32'(CPU_RD_DAT), 32'h0);
      chk("rst_rd_ack",   32'(CPU_RD_ACK), 32'h0);
      chk("rst_mem_adr",  32'(MEM_ADR), 32'h0);
      chk("rst_mem_oe",   32'(MEM_OE), 32'h0);
      chk("rst_mem_we",   32'(MEM_WE), 32'h0);
      chk("rst_mem_dout", 32'(MEM_DOUT), 32'h0);
      RESET = 1'b0;

      // Sprite read
      SPVRAMACCESSING = 1'b1; PRAMADR = 17'h01E00;
      wait_slot_start();
      chk("spr_mem_adr", 32'(MEM_ADR), 32'h01E00);
      chk("spr_mem_oe",  32'(MEM_OE), 32'h1);
      tick();
      chk("spr_pramdat", 32'(PRAMDAT), 32'hD8);
      SPVRAMACCESSING = 1'b0;
      tick();
      chk("spr_oe_drop", 32'(MEM_OE), 32'h0);

      // Interleaved and linear address mapping
      VRAMINTERLEAVEMODE = 1'b1; SPVRAMACCESSING = 1'b1; PRAMADR = 17'h03801;
      wait_slot_start();
      chk("il1_mem_adr", 32'(MEM_ADR), 32'h11C00);
      tick();
      chk("il1_pramdat", 32'(PRAMDAT), 32'h3C);
      VRAMINTERLEAVEMODE = 1'b0;
      wait_slot_start();
      chk("il0_mem_adr", 32'(MEM_ADR), 32'h03801);
      tick();
      chk("il0_pramdat", 32'(PRAMDAT), 32'h7E);

      // Priority: sprite beats buffered write
      PRAMADR = 17'h00100;
      we0 = we_cnt;
      wl_adr.delete(); wl_dat.delete(); wl_cyc.delete();
      cpu_write(17'h00200, 8'hA5, 20, ok);
      chk("pri_wr_ack", 32'(ok), 32'h1);
      wait_slot_start();
      chk("pri_spr_we",  32'(MEM_WE), 32'h0);
      chk("pri_spr_adr", 32'(MEM_ADR), 32'h00100);
      SPVRAMACCESSING = 1'b0;
      tick();
      chk("pri_spr_dat", 32'(PRAMDAT), 32'h11);
      wait_slot_start();
      chk("pri_wr_we",   32'(MEM_WE), 32'h1);
      chk("pri_wr_adr",  32'(MEM_ADR), 32'h00200);
      chk("pri_wr_dout", 32'(MEM_DOUT), 32'hA5);
      tick();
      chk("pri_we_drop", 32'(MEM_WE), 32'h0);
      chk("pri_we_cnt",  we_cnt - we0, 32'h1);
      chk("pri_vram",    32'(vram[17'h00200]), 32'hA5);

      // FIFO full: two accepts, third held until first pop
      wl_adr.delete(); wl_dat.delete(); wl_cyc.delete();
      SPVRAMACCESSING = 1'b1;
      cpu_write(17'h00300, 8'h01, 10, ok);
      chk("full_ack0", 32'(ok), 32'h1);
      cpu_write(17'h00301, 8'h02, 10, ok);
      chk("full_ack1", 32'(ok), 32'h1);
      cpu_write(17'h00302, 8'h03, 12, ok);
      chk("full_no_ack2", 32'(ok), 32'h0);
      SPVRAMACCESSING = 1'b0;
      cpu_write(17'h00302, 8'h03, 30, ok);
      ack_cyc = cyc;
      chk("full_ack2", 32'(ok), 32'h1);
      chk("full_ack_after_pop", 32'(wl_cyc.size() > 0 && ack_cyc > wl_cyc[0]), 32'h1);
      for (int i = 0; i < 40 && wl_adr.size() < 3; i++) tick();
      chk("full_nwrites", 32'(wl_adr.size()), 32'h3);
      for (int i = 0; i < 3 && i < wl_adr.size(); i++) begin
         chk($sformatf("full_order_adr%0d", i), 32'(wl_adr[i]), 32'h00300 + 32'(i));
         chk($sformatf("full_order_dat%0d", i), 32'(wl_dat[i]), 32'h01 + 32'(i));
      end

      // Read after write ordering
      wl_adr.delete(); wl_dat.delete(); wl_cyc.delete();
      cpu_write(17'h01C00, 8'h55, 20, ok);
      chk("raw_wr_ack", 32'(ok), 32'h1);
      cpu_read(17'h01C00, 40, ok, rd, rcyc);
      chk("raw_rd_ack", 32'(ok), 32'h1);
      chk("raw_rd_dat", 32'(rd), 32'h55);
      chk("raw_ack_after_we", 32'(wl_cyc.size() > 0 && rcyc > wl_cyc[0]), 32'h1);
      tick(); tick(); tick();
      chk("raw_dat_held", 32'(CPU_RD_DAT), 32'h55);
      chk("raw_ack_low",  32'(CPU_RD_ACK), 32'h0);
      cpu_read(17'h00400, 40, ok, rd, rcyc);
      chk("rd2_ack", 32'(ok), 32'h1);
      chk("rd2_dat", 32'(rd), 32'h9C);
      tick(); tick();

      // Reset during a write slot with a second write and a read pending
      SPVRAMACCESSING = 1'b1;
      cpu_write(17'h00500, 8'h66, 10, ok);
      chk("rst_q_ack0", 32'(ok), 32'h1);
      cpu_write(17'h00501, 8'h77, 10, ok);
      chk("rst_q_ack1", 32'(ok), 32'h1);
      CPU_RD_ADR = 17'h00400; CPU_RD_REQ = 1'b1;
      tick();
      SPVRAMACCESSING = 1'b0;
      wait_slot_start();
      chk("rst_slot_we",  32'(MEM_WE), 32'h1);
      chk("rst_slot_adr", 32'(MEM_ADR), 32'h00500);
      rd0 = rd_ack_cnt; wa0 = wr_ack_cnt;
      RESET = 1'b1; CPU_RD_REQ = 1'b0;
      tick();
      chk("rst_mid_we",     32'(MEM_WE), 32'h0);
      chk("rst_mid_oe",     32'(MEM_OE), 32'h0);
      chk("rst_mid_wr_ack", 32'(CPU_WR_ACK), 32'h0);
      chk("rst_mid_rd_ack", 32'(CPU_RD_ACK), 32'h0);
      we0 = we_cnt;
      RESET = 1'b0;
      for (int i = 0; i < 16; i++) tick();
      chk("rst_fifo_flushed", we_cnt - we0, 32'h0);
      chk("rst_no_rd_ack",    rd_ack_cnt - rd0, 32'h0);
      chk("rst_no_wr_ack",    wr_ack_cnt - wa0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
